// File: rtl/starfield_mixer_pkg.sv
// Shared constants, fade FSM encoding and colour helpers for the starfield mixer.
package starfield_mixer_pkg;

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CHAN_W = 8;
  localparam int unsigned RGB_W  = 3 * CHAN_W;
  localparam int unsigned RATE_W = 4;

  localparam logic [ADDR_W-1:0] ADDR_TINT    = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_THRESH  = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_FADE    = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_TWINKLE = 2'd3;

  localparam logic [CHAN_W-1:0] FADE_STEP_DEFAULT  = 8'd17;
  localparam logic [DATA_W-1:0] TINT_RESET_DEFAULT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE_OFF   = 2'd0,
    FADING_IN  = 2'd1,
    IDLE_ON    = 2'd2,
    FADING_OUT = 2'd3
  } fade_state_t;

  typedef struct packed {
    logic [CHAN_W-1:0] r;
    logic [CHAN_W-1:0] g;
    logic [CHAN_W-1:0] b;
  } rgb888_t;

  // Bit-replicating RGB332 -> RGB888 expansion so full-scale maps to 8'hFF.
  function automatic rgb888_t expand_rgb332(input logic [DATA_W-1:0] c);
    rgb888_t o;
    o.r = {c[7:5], c[7:5], c[7:6]};
    o.g = {c[4:2], c[4:2], c[4:3]};
    o.b = {c[1:0], c[1:0], c[1:0], c[1:0]};
    return o;
  endfunction

endpackage

// File: rtl/starfield_mixer_if.sv
// Pixel stream, frame timing and CPU register bus of the starfield mixer.
interface starfield_mixer_if;
  import starfield_mixer_pkg::*;

  logic              en;
  logic              vblank;
  logic              sf_on;
  logic [CHAN_W-1:0] sf_star;
  logic              fg_on;
  logic [RGB_W-1:0]  fg_rgb;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic              write;
  logic [RGB_W-1:0]  rgb_out;
  logic              fade_done;

  modport master (
    output en, vblank, sf_on, sf_star, fg_on, fg_rgb, addr, data_in, write,
    input  rgb_out, fade_done
  );

  modport slave (
    input  en, vblank, sf_on, sf_star, fg_on, fg_rgb, addr, data_in, write,
    output rgb_out, fade_done
  );
endinterface

// File: rtl/starfield_fade_ctrl.sv
// Frame tick detection, frame counter and the per-frame fade level state machine.
module starfield_fade_ctrl
  import starfield_mixer_pkg::*;
#(
  parameter logic [CHAN_W-1:0] FADE_STEP = FADE_STEP_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vblank,
  input  logic              cmd_wr,
  input  logic              cmd_target,
  input  logic [RATE_W-1:0] cmd_rate,
  output logic [CHAN_W-1:0] fade_level,
  output logic [7:0]        frame_cnt,
  output logic              fade_done
);

  fade_state_t       state_q, state_d;
  logic [CHAN_W-1:0] level_q, level_d;
  logic [RATE_W-1:0] step_q, step_d;
  logic [RATE_W-1:0] rate_q, rate_d;
  logic [7:0]        frame_q, frame_d;
  logic              vblank_q;

  logic              tick_c;
  logic              fading_c;
  logic              same_idle_c;
  logic [RATE_W:0]   step_inc_c;
  logic [CHAN_W:0]   level_up_c;

  assign tick_c      = vblank && !vblank_q;
  assign fading_c    = (state_q == FADING_IN) || (state_q == FADING_OUT);
  assign same_idle_c = (state_q == IDLE_ON && cmd_target) || (state_q == IDLE_OFF && !cmd_target);
  assign step_inc_c  = (RATE_W+1)'(step_q) + (RATE_W+1)'(1);
  assign level_up_c  = (CHAN_W+1)'(level_q) + (CHAN_W+1)'(FADE_STEP);

  // Next-state: a command write wins over a coincident tick; ticks step only while fading.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    step_d  = step_q;
    rate_d  = rate_q;
    frame_d = tick_c ? frame_q + 8'd1 : frame_q;
    if (cmd_wr) begin
      if (cmd_rate == '0) begin
        level_d = cmd_target ? 8'hFF : 8'h00;
        state_d = cmd_target ? IDLE_ON : IDLE_OFF;
        rate_d  = cmd_rate;
        step_d  = '0;
      end else if (!same_idle_c) begin
        state_d = cmd_target ? FADING_IN : FADING_OUT;
        rate_d  = cmd_rate;
        step_d  = '0;
      end
    end else if (tick_c && fading_c) begin
      if (step_inc_c == (RATE_W+1)'(rate_q)) begin
        step_d = '0;
        if (state_q == FADING_IN) begin
          if (level_up_c >= (CHAN_W+1)'(255)) begin
            level_d = 8'hFF;
            state_d = IDLE_ON;
          end else begin
            level_d = level_up_c[CHAN_W-1:0];
          end
        end else begin
          if (level_q <= FADE_STEP) begin
            level_d = 8'h00;
            state_d = IDLE_OFF;
          end else begin
            level_d = level_q - FADE_STEP;
          end
        end
      end else begin
        step_d = step_inc_c[RATE_W-1:0];
      end
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE_OFF;
      level_q  <= '0;
      step_q   <= '0;
      rate_q   <= '0;
      frame_q  <= '0;
      vblank_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      step_q   <= step_d;
      rate_q   <= rate_d;
      frame_q  <= frame_d;
      vblank_q <= vblank;
    end
  end

  assign fade_level = level_q;
  assign frame_cnt  = frame_q;
  assign fade_done  = (state_q == IDLE_OFF) || (state_q == IDLE_ON);

endmodule

// File: rtl/starfield_mixer.sv
// Starfield pixel pipeline: threshold, twinkle, fade and tint, composited under foreground.
module starfield_mixer
  import starfield_mixer_pkg::*;
#(
  parameter logic [CHAN_W-1:0] FADE_STEP  = FADE_STEP_DEFAULT,
  parameter logic [DATA_W-1:0] TINT_RESET = TINT_RESET_DEFAULT
) (
  input logic               clk,
  input logic               rst_n,
  starfield_mixer_if.slave  bus
);

  logic [DATA_W-1:0] tint_q;
  logic [DATA_W-1:0] thresh_q;
  logic              twinkle_q;

  logic [CHAN_W-1:0] fade_level;
  logic [7:0]        frame_cnt;
  logic              fade_done;
  logic              fade_wr_c;

  logic              s1_valid_q;
  logic [CHAN_W-1:0] level1_q;
  logic              fg_on1_q;
  logic [RGB_W-1:0]  fg_rgb1_q;
  logic [RGB_W-1:0]  rgb_out_q;

  logic              twinkle_hit_c;
  logic              star_ok_c;
  logic [15:0]       fade_prod_c;
  logic [CHAN_W-1:0] lvl2_c;
  rgb888_t           tint8_c;
  logic [15:0]       r_prod_c, g_prod_c, b_prod_c;
  logic [RGB_W-1:0]  star_rgb_c;
  logic              unused_frame_bits;

  assign fade_wr_c = bus.write && (bus.addr == ADDR_FADE);

  // CPU register writes, taken regardless of pixel enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tint_q    <= TINT_RESET;
      thresh_q  <= '0;
      twinkle_q <= 1'b0;
    end else if (bus.write) begin
      case (bus.addr)
        ADDR_TINT:    tint_q    <= bus.data_in;
        ADDR_THRESH:  thresh_q  <= bus.data_in;
        ADDR_TWINKLE: twinkle_q <= bus.data_in[0];
        default:      ;
      endcase
    end
  end

  starfield_fade_ctrl #(
    .FADE_STEP (FADE_STEP)
  ) u_fade (
    .clk        (clk),
    .rst_n      (rst_n),
    .vblank     (bus.vblank),
    .cmd_wr     (fade_wr_c),
    .cmd_target (bus.data_in[0]),
    .cmd_rate   (bus.data_in[7:4]),
    .fade_level (fade_level),
    .frame_cnt  (frame_cnt),
    .fade_done  (fade_done)
  );

  assign unused_frame_bits = ^{frame_cnt[7:6], frame_cnt[2:0]};

  // Stage 1 gating: threshold plus a twinkle phase that rotates every 8 frames.
  assign twinkle_hit_c = twinkle_q && (3'(bus.sf_star[7:5] + frame_cnt[5:3]) == 3'd0);
  assign star_ok_c     = bus.sf_on && (bus.sf_star >= thresh_q) && !twinkle_hit_c;

  // Stage 1 registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      level1_q   <= '0;
      fg_on1_q   <= 1'b0;
      fg_rgb1_q  <= '0;
    end else if (bus.en) begin
      s1_valid_q <= 1'b1;
      level1_q   <= star_ok_c ? bus.sf_star : '0;
      fg_on1_q   <= bus.fg_on;
      fg_rgb1_q  <= bus.fg_rgb;
    end
  end

  // Stage 2 fade and tint, using live fade level and tint.
  assign fade_prod_c = 16'(level1_q) * 16'(fade_level);
  assign lvl2_c      = fade_prod_c[15:8];
  assign tint8_c     = expand_rgb332(tint_q);
  assign r_prod_c    = 16'(lvl2_c) * 16'(tint8_c.r);
  assign g_prod_c    = 16'(lvl2_c) * 16'(tint8_c.g);
  assign b_prod_c    = 16'(lvl2_c) * 16'(tint8_c.b);
  assign star_rgb_c  = {r_prod_c[15:8], g_prod_c[15:8], b_prod_c[15:8]};

  // Stage 2 output register: foreground over tinted star.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_out_q <= '0;
    end else if (bus.en) begin
      if (fg_on1_q) begin
        rgb_out_q <= fg_rgb1_q;
      end else if (s1_valid_q) begin
        rgb_out_q <= star_rgb_c;
      end else begin
        rgb_out_q <= '0;
      end
    end
  end

  assign bus.rgb_out   = rgb_out_q;
  assign bus.fade_done = fade_done;

endmodule

// File: tb/tb_starfield_mixer.sv
// Directed scoreboard bench for starfield_mixer.
module tb_starfield_mixer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  logic [23:0] exp_q [$];
  logic [7:0]  fade_m  = 8'd0;
  logic [7:0]  tint_m  = 8'hFF;
  logic [7:0]  thr_m   = 8'd0;
  bit          tw_m    = 1'b0;
  logic [7:0]  frame_m = 8'd0;
  logic [23:0] last_e;

  starfield_mixer_if sif ();

  starfield_mixer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference pixel: foreground, else gated star scaled by fade then by expanded tint.
  function automatic logic [23:0] exp_pix(bit on, logic [7:0] star, bit fg, logic [23:0] fgc);
    int lvl, r3, g3, b2, r8, g8, b8;
    if (fg) return fgc;
    lvl = (on && star >= thr_m) ? int'(star) : 0;
    if (tw_m && (((int'(star) >> 5) + (int'(frame_m) >> 3)) % 8 == 0)) lvl = 0;
    lvl = lvl * int'(fade_m) / 256;
    r3 = int'(tint_m) >> 5;
    g3 = (int'(tint_m) >> 2) % 8;
    b2 = int'(tint_m) % 4;
    r8 = r3 * 36 + r3 / 2;
    g8 = g3 * 36 + g3 / 2;
    b8 = b2 * 85;
    return {8'(lvl * r8 / 256), 8'(lvl * g8 / 256), 8'(lvl * b8 / 256)};
  endfunction

  task automatic cpu_wr(input logic [1:0] a, input logic [7:0] d);
    sif.en = 1'b0;
    sif.addr = a;
    sif.data_in = d;
    sif.write = 1'b1;
    @(posedge clk); #1;
    sif.write = 1'b0;
  endtask

  task automatic tick();
    sif.vblank = 1'b1;
    @(posedge clk); #1;
    sif.vblank = 1'b0;
    @(posedge clk); #1;
    frame_m++;
  endtask

  // One enabled pixel; the output of the previous pixel is popped and compared.
  task automatic px(input bit on, input logic [7:0] star, input bit fg, input logic [23:0] fgc,
                    input string tag);
    sif.en = 1'b1;
    sif.sf_on = on;
    sif.sf_star = star;
    sif.fg_on = fg;
    sif.fg_rgb = fgc;
    exp_q.push_back(exp_pix(on, star, fg, fgc));
    @(posedge clk); #1;
    sif.en = 1'b0;
    if (exp_q.size() > 1) begin
      last_e = exp_q.pop_front();
      chk(tag, 32'(sif.rgb_out), 32'(last_e));
    end
  endtask

  task automatic drain();
    px(1'b0, 8'd0, 1'b0, 24'd0, "drain");
  endtask

  initial begin
    sif.en = 0; sif.vblank = 0; sif.sf_on = 0; sif.sf_star = 0;
    sif.fg_on = 0; sif.fg_rgb = 0; sif.addr = 0; sif.data_in = 0; sif.write = 0;
    #12 rst_n = 1'b1;
    #1;
    chk("rst_rgb", 32'(sif.rgb_out), 32'h0);
    chk("rst_done", 32'(sif.fade_done), 32'h1);
    chk("rst_level", 32'(dut.fade_level), 32'h0);

    // Immediate fade on, steady star
    cpu_wr(2'd2, 8'h01); fade_m = 8'hFF;
    chk("t1_level", 32'(dut.fade_level), 32'hFF);
    px(1'b1, 8'hC8, 1'b0, 24'd0, "t1_a");
    px(1'b1, 8'hC8, 1'b0, 24'd0, "t1_b");
    chk("t1_const", 32'(sif.rgb_out), 32'hC6C6C6);
    chk("t1_done", 32'(sif.fade_done), 32'h1);
    drain();

    // Fade in over 30 frames at rate 2
    cpu_wr(2'd2, 8'h00); fade_m = 8'h00;
    cpu_wr(2'd2, 8'h21);
    chk("t2_start_done", 32'(sif.fade_done), 32'h0);
    chk("t2_start_level", 32'(dut.fade_level), 32'h0);
    for (int t = 1; t <= 30; t++) begin
      tick();
      chk("t2_level", 32'(dut.fade_level), 32'((t / 2) * 17));
      chk("t2_done", 32'(sif.fade_done), 32'(t == 30));
    end
    chk("t2_frame", 32'(dut.frame_cnt), 32'(frame_m));

    // Reversal mid-fade at 85
    cpu_wr(2'd2, 8'h00);
    cpu_wr(2'd2, 8'h21);
    for (int t = 0; t < 10; t++) tick();
    chk("t3_at85", 32'(dut.fade_level), 32'd85);
    cpu_wr(2'd2, 8'h20);
    chk("t3_rev_done", 32'(sif.fade_done), 32'h0);
    tick();
    chk("t3_hold85", 32'(dut.fade_level), 32'd85);
    tick();
    chk("t3_68", 32'(dut.fade_level), 32'd68);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("t3_down", 32'(dut.fade_level), 32'(68 - 17 * (k / 2)));
      chk("t3_down_done", 32'(sif.fade_done), 32'(k == 8));
    end

    // Command coincident with tick drops the step but still counts the frame
    cpu_wr(2'd2, 8'h11);
    tick();
    chk("t3_r1_step", 32'(dut.fade_level), 32'd17);
    sif.vblank = 1'b1; sif.addr = 2'd2; sif.data_in = 8'h11; sif.write = 1'b1;
    @(posedge clk); #1;
    sif.write = 1'b0; sif.vblank = 1'b0;
    @(posedge clk); #1;
    frame_m++;
    chk("t3_coinc_level", 32'(dut.fade_level), 32'd17);
    chk("t3_coinc_frame", 32'(dut.frame_cnt), 32'(frame_m));
    tick();
    chk("t3_after_coinc", 32'(dut.fade_level), 32'd34);

    // Threshold and foreground
    cpu_wr(2'd2, 8'h01); fade_m = 8'hFF;
    cpu_wr(2'd1, 8'h80); thr_m = 8'h80;
    drain();
    px(1'b1, 8'h7F, 1'b0, 24'd0, "t4_below");
    px(1'b1, 8'h80, 1'b0, 24'd0, "t4_below_out");
    chk("t4_below_zero", 32'(sif.rgb_out), 32'h0);
    px(1'b1, 8'hFF, 1'b1, 24'h123456, "t4_at_out");
    chk("t4_at_nz", 32'(sif.rgb_out != 24'd0), 32'h1);
    px(1'b0, 8'h00, 1'b0, 24'd0, "t4_fg_out");
    chk("t4_fg_const", 32'(sif.rgb_out), 32'h123456);

    // Enable stall with a non-white tint
    cpu_wr(2'd0, 8'b101_010_01); tint_m = 8'b101_010_01;
    drain();
    px(1'b1, 8'hF0, 1'b0, 24'd0, "t5_a");
    px(1'b1, 8'hA0, 1'b0, 24'd0, "t5_b");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("t5_hold", 32'(sif.rgb_out), 32'(last_e));
    end
    px(1'b1, 8'hD0, 1'b0, 24'd0, "t5_c");
    px(1'b1, 8'h90, 1'b0, 24'd0, "t5_d");
    drain();

    // Twinkle at frame phase 3
    cpu_wr(2'd3, 8'h01); tw_m = 1'b1;
    for (int g = 0; g < 80 && frame_m[5:3] != 3'd3; g++) tick();
    chk("tw_phase", 32'(dut.frame_cnt[5:3]), 32'd3);
    px(1'b1, 8'hA0, 1'b0, 24'd0, "tw_sup_in");
    px(1'b1, 8'h80, 1'b0, 24'd0, "tw_sup");
    chk("tw_sup_zero", 32'(sif.rgb_out), 32'h0);
    drain();
    chk("tw_vis_nz", 32'(sif.rgb_out != 24'd0), 32'h1);
    cpu_wr(2'd3, 8'h00); tw_m = 1'b0;

    // Async reset in the middle of a fade-out
    cpu_wr(2'd2, 8'h10);
    tick();
    chk("t6_level", 32'(dut.fade_level), 32'd238);
    chk("t6_fading", 32'(sif.fade_done), 32'h0);
    px(1'b0, 8'h00, 1'b1, 24'hABCDEF, "t6_a");
    px(1'b0, 8'h00, 1'b1, 24'hABCDEF, "t6_b");
    chk("t6_pre_rst", 32'(sif.rgb_out), 32'hABCDEF);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_rgb", 32'(sif.rgb_out), 32'h0);
    chk("t6_rst_done", 32'(sif.fade_done), 32'h1);
    chk("t6_rst_level", 32'(dut.fade_level), 32'h0);
    #3 rst_n = 1'b1;
    exp_q.delete();
    fade_m = 8'd0; tint_m = 8'hFF; thr_m = 8'd0; tw_m = 1'b0; frame_m = 8'd0;
    chk("t6_frame", 32'(dut.frame_cnt), 32'h0);
    px(1'b1, 8'hFF, 1'b0, 24'd0, "t6_c");
    px(1'b1, 8'hFF, 1'b0, 24'd0, "t6_dark");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
